// File: rtl/alu_ctrl_pkg.sv
// Shared ALU operation codes, opcode/func encodings and the instruction decode
// function used by the ALU control sequencer.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_NOR  = 4'd4;
  localparam logic [3:0] ALU_SLL1 = 4'd5;
  localparam logic [3:0] ALU_SRL1 = 4'd6;
  localparam logic [3:0] ALU_SUB  = 4'd7;
  localparam logic [3:0] ALU_SRA1 = 4'd8;
  localparam logic [3:0] ALU_EQ0  = 4'd14;
  localparam logic [3:0] ALU_SLT  = 4'd15;

  localparam logic [7:0] OP_RTYPE = 8'd0;
  localparam logic [7:0] OP_ILL7  = 8'd7;
  localparam logic [7:0] OP_ORI   = 8'd9;
  localparam logic [7:0] OP_ANDI  = 8'd10;
  localparam logic [7:0] OP_NORI  = 8'd11;
  localparam logic [7:0] OP_SLL   = 8'd12;
  localparam logic [7:0] OP_SRL   = 8'd13;
  localparam logic [7:0] OP_SRA   = 8'd14;
  localparam logic [7:0] OP_SLTI  = 8'd15;

  localparam logic [7:0] FN_ADD  = 8'd0;
  localparam logic [7:0] FN_AND  = 8'd1;
  localparam logic [7:0] FN_OR   = 8'd2;
  localparam logic [7:0] FN_XOR  = 8'd3;
  localparam logic [7:0] FN_NOR  = 8'd4;
  localparam logic [7:0] FN_COPY = 8'd6;
  localparam logic [7:0] FN_JR   = 8'd7;
  localparam logic [7:0] FN_SLT  = 8'd9;
  localparam logic [7:0] FN_EQ0A = 8'd10;
  localparam logic [7:0] FN_EQ0B = 8'd11;

  typedef struct packed {
    logic [3:0] code;
    logic       is_shift;
    logic       illegal;
  } dec_t;

  // Unlisted encodings fall back to ADD and are flagged illegal.
  function automatic dec_t decode(input logic [7:0] op, input logic [7:0] func);
    dec_t d;
    d.code     = ALU_ADD;
    d.is_shift = 1'b0;
    d.illegal  = 1'b0;
    if (op == OP_RTYPE) begin
      case (func)
        FN_ADD, FN_COPY, FN_JR: d.code = ALU_ADD;
        FN_AND:                 d.code = ALU_AND;
        FN_OR:                  d.code = ALU_OR;
        FN_XOR:                 d.code = ALU_XOR;
        FN_NOR:                 d.code = ALU_NOR;
        FN_SLT:                 d.code = ALU_SLT;
        FN_EQ0A, FN_EQ0B:       d.code = ALU_EQ0;
        default:                d.illegal = 1'b1;
      endcase
    end else begin
      case (op)
        8'd1, 8'd4, 8'd5, 8'd6, 8'd8: d.code = ALU_ADD;
        8'd2, 8'd3:                   d.code = ALU_SUB;
        OP_ILL7:                      d.illegal = 1'b1;
        OP_ORI:                       d.code = ALU_OR;
        OP_ANDI:                      d.code = ALU_AND;
        OP_NORI:                      d.code = ALU_NOR;
        OP_SLTI:                      d.code = ALU_SLT;
        OP_SLL: begin d.code = ALU_SLL1; d.is_shift = 1'b1; end
        OP_SRL: begin d.code = ALU_SRL1; d.is_shift = 1'b1; end
        OP_SRA: begin d.code = ALU_SRA1; d.is_shift = 1'b1; end
        default:                      d.illegal = 1'b1;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Purely combinational op/func decode into ALU code, shift flag and illegal flag.
module alu_ctrl_decode #(
  parameter int OP_W    = 4,
  parameter int FUNC_W  = 4,
  parameter int ALUOP_W = 4
) (
  input  logic [OP_W-1:0]    op_i,
  input  logic [FUNC_W-1:0]  func_i,
  output logic [ALUOP_W-1:0] code_o,
  output logic               is_shift_o,
  output logic               illegal_o
);
  import alu_ctrl_pkg::*;

  dec_t dec;

  always_comb begin
    dec        = decode(8'(op_i), 8'(func_i));
    code_o     = ALUOP_W'(dec.code);
    is_shift_o = dec.is_shift;
    illegal_o  = dec.illegal;
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: decodes instructions and issues micro-ops to the ALU,
// expanding variable shifts into a run of single-bit shift micro-ops.
module alu_ctrl_seq #(
  parameter int OP_W    = 4,
  parameter int FUNC_W  = 4,
  parameter int SHAMT_W = 4,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNC_W-1:0]  func,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               out_first,
  output logic               out_last,
  output logic               out_illegal
);
  import alu_ctrl_pkg::*;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t             state_q;
  logic [SHAMT_W-1:0] rem_q;
  logic [ALUOP_W-1:0] alu_op_q;
  logic               first_q;
  logic               illegal_q;

  logic [ALUOP_W-1:0] dec_code;
  logic               dec_shift;
  logic               dec_illegal;
  logic               shamt_zero;
  logic [SHAMT_W-1:0] rem_d;
  logic [ALUOP_W-1:0] code_d;
  logic               accept;
  logic               fire;

  alu_ctrl_decode #(
    .OP_W    (OP_W),
    .FUNC_W  (FUNC_W),
    .ALUOP_W (ALUOP_W)
  ) u_decode (
    .op_i       (op),
    .func_i     (func),
    .code_o     (dec_code),
    .is_shift_o (dec_shift),
    .illegal_o  (dec_illegal)
  );

  // A shift by zero degenerates into a single ADD pass-through micro-op.
  assign shamt_zero = (shamt == '0);
  assign rem_d      = (dec_shift && !shamt_zero) ? shamt : SHAMT_W'(1);
  assign code_d     = (dec_shift && shamt_zero) ? ALUOP_W'(ALU_ADD) : dec_code;

  assign out_valid   = (state_q == S_ISSUE);
  assign out_last    = out_valid && (rem_q == SHAMT_W'(1));
  assign in_ready    = !out_valid || (out_ready && out_last);
  assign accept      = in_valid && in_ready;
  assign fire        = out_valid && out_ready;
  assign alu_op      = alu_op_q;
  assign out_first   = first_q;
  assign out_illegal = illegal_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      alu_op_q  <= '0;
      first_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q   <= S_ISSUE;
            rem_q     <= rem_d;
            alu_op_q  <= code_d;
            first_q   <= 1'b1;
            illegal_q <= dec_illegal;
          end
        end
        S_ISSUE: begin
          // accept is only possible here together with the final handshake
          if (accept) begin
            rem_q     <= rem_d;
            alu_op_q  <= code_d;
            first_q   <= 1'b1;
            illegal_q <= dec_illegal;
          end else if (fire) begin
            if (rem_q > SHAMT_W'(1)) begin
              rem_q   <= rem_q - SHAMT_W'(1);
              first_q <= 1'b0;
            end else begin
              state_q   <= S_IDLE;
              rem_q     <= '0;
              alu_op_q  <= '0;
              first_q   <= 1'b0;
              illegal_q <= 1'b0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: a micro-op queue model checked every cycle, plus
// literal expectations on the handshaked micro-op log for directed scenarios.
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [3:0] op = '0, func = '0, shamt = '0;
  logic       in_ready, out_valid, out_first, out_last, out_illegal;
  logic [3:0] alu_op;

  alu_ctrl_seq #(.OP_W(4), .FUNC_W(4), .SHAMT_W(4), .ALUOP_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .func(func), .shamt(shamt), .out_valid(out_valid),
    .out_ready(out_ready), .alu_op(alu_op), .out_first(out_first),
    .out_last(out_last), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  // Decode tables written straight from the encoding lists.
  localparam int R_CODE [16] = '{0, 3, 1, 2, 4, 0, 0, 0, 0, 15, 14, 14, 0, 0, 0, 0};
  localparam int R_ILL  [16] = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1};
  localparam int I_CODE [16] = '{0, 0, 7, 7, 0, 0, 0, 0, 0, 1, 3, 4, 5, 6, 8, 15};
  localparam int I_ILL  [16] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};

  typedef struct {
    int code;
    int f;
    int l;
    int ill;
  } uop_t;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  uop_t q[$];
  uop_t log_q[$];
  int   log_cyc[$];

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void push_instr(input int o, input int fn, input int sh);
    int code, ill, shift, n;
    if (o == 0) begin
      code = R_CODE[fn]; ill = R_ILL[fn]; shift = 0;
    end else begin
      code = I_CODE[o]; ill = I_ILL[o]; shift = (o >= 12 && o <= 14) ? 1 : 0;
    end
    n = (shift != 0 && sh > 0) ? sh : 1;
    if (shift != 0 && sh == 0) code = 0;
    for (int i = 0; i < n; i++)
      q.push_back('{code, (i == 0) ? 1 : 0, (i == n - 1) ? 1 : 0, ill});
  endfunction

  function automatic int mdl_ready();
    return (q.size() == 0 || (out_ready && q.size() == 1)) ? 1 : 0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge reset) begin
    if (reset) q.delete();
    else if (in_valid && mdl_ready() != 0) begin
      if (q.size() > 0) q.delete(0);
      push_instr(int'(op), int'(func), int'(shamt));
    end else if (q.size() > 0 && out_ready) q.delete(0);
  end

  always @(negedge clk) begin
    if (reset) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_alu_op", alu_op, 0);
      check("rst_out_first", out_first, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_illegal", out_illegal, 0);
      check("rst_in_ready", in_ready, 1);
    end else begin
      check("out_valid", out_valid, (q.size() > 0) ? 1 : 0);
      check("in_ready", in_ready, mdl_ready());
      if (q.size() > 0) begin
        check("alu_op", alu_op, q[0].code);
        check("out_first", out_first, q[0].f);
        check("out_last", out_last, q[0].l);
        check("out_illegal", out_illegal, q[0].ill);
      end
      if (out_valid && out_ready) begin
        log_q.push_back('{int'(alu_op), int'(out_first), int'(out_last), int'(out_illegal)});
        log_cyc.push_back(cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int o, input int fn, input int sh);
    int n = 0;
    bit ok = 1'b0;
    op = 4'(o); func = 4'(fn); shamt = 4'(sh); in_valid = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    check("accept_timeout", int'(ok), 1);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 200) begin @(posedge clk); #1; n++; end
    idle(1);
    check("drain_timeout", q.size(), 0);
  endtask

  task automatic clear_log();
    log_q.delete();
    log_cyc.delete();
  endtask

  task automatic expect_log(input string nm, input int idx, input int code,
                            input int f, input int l, input int ill);
    if (idx >= log_q.size()) begin
      check({nm, "_present"}, log_q.size(), idx + 1);
    end else begin
      check({nm, "_code"}, log_q[idx].code, code);
      check({nm, "_first"}, log_q[idx].f, f);
      check({nm, "_last"}, log_q[idx].l, l);
      check({nm, "_ill"}, log_q[idx].ill, ill);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle(1);

    // back-to-back single-step ops
    clear_log();
    send(0, 0, 0);
    send(10, 0, 0);
    drain();
    check("b2b_count", log_q.size(), 2);
    expect_log("b2b0", 0, 0, 1, 1, 0);
    expect_log("b2b1", 1, 3, 1, 1, 0);
    if (log_cyc.size() >= 2) check("b2b_gap", log_cyc[1] - log_cyc[0], 1);

    // srl by 3
    clear_log();
    send(13, 0, 3);
    drain();
    check("srl3_count", log_q.size(), 3);
    expect_log("srl3_0", 0, 6, 1, 0, 0);
    expect_log("srl3_1", 1, 6, 0, 0, 0);
    expect_log("srl3_2", 2, 6, 0, 1, 0);

    // sra by 0 and by 15
    clear_log();
    send(14, 0, 0);
    drain();
    check("sra0_count", log_q.size(), 1);
    expect_log("sra0", 0, 0, 1, 1, 0);
    clear_log();
    send(14, 0, 15);
    drain();
    check("sra15_count", log_q.size(), 15);
    for (int i = 0; i < log_q.size(); i++)
      expect_log("sra15", i, 8, (i == 0) ? 1 : 0, (i == 14) ? 1 : 0, 0);

    // sll by 2 with a 4-cycle stall after the first micro-op
    clear_log();
    send(12, 0, 2);
    idle(1);
    out_ready = 1'b0;
    idle(4);
    out_ready = 1'b1;
    drain();
    check("stall_count", log_q.size(), 2);
    expect_log("stall0", 0, 5, 1, 0, 0);
    expect_log("stall1", 1, 5, 0, 1, 0);

    // illegal encodings followed by a legal ORI
    clear_log();
    send(0, 12, 0);
    send(7, 0, 0);
    send(9, 0, 0);
    drain();
    check("ill_count", log_q.size(), 3);
    expect_log("ill_fn12", 0, 0, 1, 1, 1);
    expect_log("ill_op7", 1, 0, 1, 1, 1);
    expect_log("ori", 2, 1, 1, 1, 0);

    // full decode sweep, checked by the model
    for (int fn = 0; fn < 16; fn++) send(0, fn, 0);
    for (int o = 1; o < 16; o++) send(o, 0, 1);
    drain();

    // reset in the middle of a shift by 5
    clear_log();
    send(12, 0, 5);
    idle(2);
    reset = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_alu_op", alu_op, 0);
    check("midrst_out_first", out_first, 0);
    check("midrst_out_last", out_last, 0);
    check("midrst_in_ready", in_ready, 1);
    idle(2);
    reset = 1'b0;
    idle(8);
    check("midrst_log_count", log_q.size(), 2);
    check("midrst_after_valid", out_valid, 0);
    check("midrst_after_ready", in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Registered, parametrised ALU control unit that decodes op/func into an ALU operation code and sequences multi-step operations. Variable shifts (sll/srl/sra by `shamt`) become a stream of single-bit-shift micro-ops for the 1-bit shifter ALU. The block sits between instruction decode and the ALU. It uses valid/ready handshakes on both sides, so the control FSM can stall fetch while a shift is being sequenced.

## Interface
- `OP_W`, 4, opcode width
- `FUNC_W`, 4, R-type function field width
- `SHAMT_W`, 4, shift-amount width; the longest sequence is 2^SHAMT_W−1 micro-ops
- `ALUOP_W`, 4, ALU operation code width
- `clk`  in  1  clock, rising edge
- `reset`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  decoded instruction fields valid
- `in_ready`  out  1  block can accept a new instruction
- `op`  in  OP_W  opcode
- `func`  in  FUNC_W  function field, used only when op==0
- `shamt`  in  SHAMT_W  shift amount, used only for shift ops
- `out_valid`  out  1  `alu_op` is valid for the ALU this cycle
- `out_ready`  in  1  ALU/datapath consumes the micro-op
- `alu_op`  out  ALUOP_W  ALU operation code
- `out_first`  out  1  first micro-op of an instruction (datapath selects register operand)
- `out_last`  out  1  final micro-op of an instruction (datapath writes back)
- `out_illegal`  out  1  instruction encoding is unused/illegal

## Operation
- ALU codes:
  - ADD=0, OR=1, XOR=2, AND=3, NOR=4
  - SLL1=5, SRL1=6, SUB=7, SRA1=8
  - EQ0=14, SLT=15
  - Codes are zero-extended to ALUOP_W.
- op==0 decode (by func):
  - 0→ADD, 1→AND, 2→OR, 3→XOR, 4→NOR
  - 6 (copy)→ADD, 7 (jr)→ADD
  - 9→SLT, 10/11→EQ0
  - 5, 8, 12–15 → ADD with `out_illegal`=1
- op!=0 decode:
  - 1, 5, 6→ADD; 2, 3→SUB; 4, 8→ADD; 7→ADD with `out_illegal`=1
  - 9→OR, 10→AND, 11→NOR, 15→SLT
  - 12→SLL1, 13→SRL1, 14→SRA1 (shift ops)
- Sequence length:
  - Shift op with shamt≥1: `shamt` micro-ops, all carrying the same code.
  - Shift op with shamt==0: one ADD micro-op (pass-through); `out_first`=`out_last`=1.
  - All other ops: one micro-op.
- FSM states:
  - IDLE (`out_valid`=0)
  - ISSUE (`out_valid`=1, remaining count `rem`≥1)
- Transitions:
  - IDLE → ISSUE on accept.
  - In ISSUE, on an output handshake with rem>1: `rem`−1, `out_first`←0, code and illegal flag held.
  - In ISSUE, on an output handshake with rem==1: go to IDLE, unless a new accept occurs in the same cycle; then reload and stay in ISSUE.
- `out_last` = `out_valid` && (`rem`==1).
- `in_ready` = !`out_valid` || (`out_ready` && `out_last`). This allows back-to-back single-cycle instructions with no bubble.
- Output holds stable while `out_valid` && !`out_ready`. Inputs are ignored unless `in_ready`.
- `rem` is SHAMT_W bits and never wraps. Decrement happens only when `rem`>1.

## Timing
- Latency: accept at edge N → first micro-op valid after edge N (registered outputs, no combinational input→output path except `in_ready`←`out_ready`).
- Throughput: 1 instruction/cycle for single-step ops; a shift by k occupies k cycles with `out_ready` held high.
- Reset values: `out_valid`=0, `alu_op`=0, `out_first`=0, `out_illegal`=0, `rem`=0. Consequently `out_last`=0 and `in_ready`=1.
- Reset asserted mid-sequence aborts it immediately; no trailing micro-ops after release.
- `out_ready` low on the last micro-op: `in_ready`=0, so no accept occurs.

## Structure
- Package `alu_ctrl_pkg`: ALU code localparams (ADD…SLT), opcode/func localparams, and a `decode` function returning {code, is_shift, illegal}.
- One sub-module, `alu_ctrl_decode` (purely combinational decode). The FSM, counter and handshake live in the top level.

## Test plan
- Reset mid-shift: op=12, shamt=5, assert reset after 2 micro-ops → all outputs 0 immediately; after release, `in_ready`=1 and no further micro-ops.
- Back-to-back: op=0/func=0 then op=10 with `out_ready`=1 → ADD then AND on consecutive cycles; `out_first`=`out_last`=1 on each.
- Shift sequence: op=13, shamt=3, `out_ready`=1 → SRL1 (6) for 3 cycles; `out_first` on cycle 1 only, `out_last` on cycle 3; `in_ready`=0 on cycles 1–2.
- Edge shift amounts: op=14, shamt=0 → a single ADD micro-op. op=14, shamt=15 → 15 SRA1 micro-ops.
- Stall: shift by 2 with `out_ready` held low for 4 cycles mid-sequence → `alu_op`, `out_first` and `rem` stable; no micro-op lost or duplicated.
- Illegal encodings: op=0/func=12 and op=7 → ADD with `out_illegal`=1 for one micro-op. The following legal op=9 → OR with `out_illegal`=0.
